// File: rtl/btn_repeat_if.sv
// btn_repeat_if: groups the button level and the event outputs of one
// btn_repeat instance.
//   btn_n_i   - debounced button level, 0 = pressed (driven by master)
//   press_o   - one-cycle pulse on initial press and every repeat
//   release_o - one-cycle pulse when a tracked press ends
//   held_o    - level, high while auto-repeating
//   fast_o    - level, high while the accelerated repeat period is active
// Modports: master (button side / controller), slave (btn_repeat).
interface btn_repeat_if;
    logic btn_n_i;
    logic press_o;
    logic release_o;
    logic held_o;
    logic fast_o;

    modport master (
        output btn_n_i,
        input  press_o,
        input  release_o,
        input  held_o,
        input  fast_o
    );

    modport slave (
        input  btn_n_i,
        output press_o,
        output release_o,
        output held_o,
        output fast_o
    );
endinterface

// File: rtl/btn_repeat.sv
// btn_repeat: turns one debounced active-low button level into a press
// pulse, an auto-repeat pulse train while held, and a release pulse.
// Ports:
//   clk_i - system clock
//   rst_i - asynchronous active-high reset
//   bus   - btn_repeat_if.slave (btn_n_i in; press_o, release_o, held_o,
//           fast_o out, all registered)
// Optional feature: define BTN_REPEAT_ACCEL_EN to halve the repeat period
// once ACCEL_COUNT repeat pulses have been issued (fast_o then goes high).
//
// state  | meaning
// IDLE   | no tracked press; waiting for a falling edge
// DELAY  | press pulse issued; counting to the first repeat
// REPEAT | button held; issuing a repeat pulse every period
module btn_repeat #(
    parameter int DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int ACCEL_COUNT   = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    btn_repeat_if.slave   bus
);

    localparam int MAX_CYC = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             prev;
    logic             press_q, press_next;
    logic             release_q, release_next;
    logic             held_q, held_next;
    logic             fall;
    logic [CNT_W-1:0] period_last;

`ifdef BTN_REPEAT_ACCEL_EN
    localparam int               RPT_W     = $clog2(ACCEL_COUNT + 1);
    localparam logic [RPT_W-1:0] RPT_MAX   = RPT_W'(ACCEL_COUNT);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(REPEAT_CYCLES / 2 - 1);

    logic [RPT_W-1:0] rpt, rpt_next;
    logic             fast_q, fast_next;

    // The period switches in the same edge that rpt reaches its limit, so the
    // interval following that pulse is already the short one.
    assign period_last = (rpt == RPT_MAX) ? FAST_LAST : SLOW_LAST;
`else
    assign period_last = SLOW_LAST;
`endif

    // prev resets to "pressed" so a button held through reset is ignored
    // until it has been released once.
    assign fall = prev & ~bus.btn_n_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            prev      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
`ifdef BTN_REPEAT_ACCEL_EN
            rpt       <= '0;
            fast_q    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            prev      <= bus.btn_n_i;
            press_q   <= press_next;
            release_q <= release_next;
            held_q    <= held_next;
`ifdef BTN_REPEAT_ACCEL_EN
            rpt       <= rpt_next;
            fast_q    <= fast_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        held_next    = held_q;
`ifdef BTN_REPEAT_ACCEL_EN
        rpt_next     = rpt;
        fast_next    = fast_q;
`endif
        case (state)
            IDLE: begin
                if (fall) begin
                    press_next = 1'b1;
                    cnt_next   = '0;
                    state_next = DELAY;
                end
            end
            DELAY: begin
                if (bus.btn_n_i) begin
                    release_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end else if (cnt == DELAY_LAST) begin
                    press_next = 1'b1;
                    held_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = REPEAT;
`ifdef BTN_REPEAT_ACCEL_EN
                    rpt_next   = RPT_W'(1);
                    fast_next  = (RPT_W'(1) == RPT_MAX);
`endif
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            REPEAT: begin
                // Release takes priority over a repeat that is due this edge.
                if (bus.btn_n_i) begin
                    release_next = 1'b1;
                    held_next    = 1'b0;
                    cnt_next     = '0;
                    state_next   = IDLE;
`ifdef BTN_REPEAT_ACCEL_EN
                    rpt_next     = '0;
                    fast_next    = 1'b0;
`endif
                end else if (cnt == period_last) begin
                    press_next = 1'b1;
                    cnt_next   = '0;
`ifdef BTN_REPEAT_ACCEL_EN
                    if (rpt != RPT_MAX) begin
                        rpt_next  = rpt + RPT_W'(1);
                        fast_next = ((rpt + RPT_W'(1)) == RPT_MAX);
                    end else begin
                        fast_next = 1'b1;
                    end
`endif
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                held_next  = 1'b0;
            end
        endcase
    end

    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.held_o    = held_q;
`ifdef BTN_REPEAT_ACCEL_EN
    assign bus.fast_o    = fast_q;
`else
    assign bus.fast_o    = 1'b0;
`endif

endmodule
